// File: rtl/pipe_ctrl_pkg.sv
// rtl/pipe_ctrl_pkg.sv - shared types and constants for the pipeline hazard controller
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        STALL = 2'd1,
        FLUSH = 2'd2
    } ctrl_state_t;

    typedef logic [3:0] cnt_t;

    localparam logic [4:0] REG_X0 = 5'd0;

endpackage

// File: rtl/pipe_hazard_cmp.sv
// rtl/pipe_hazard_cmp.sv - combinational load-use hazard comparator
module pipe_hazard_cmp
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] rs1,
    input  logic [4:0] rs2,
    input  logic       uses_rs2,
    input  logic [4:0] rd,
    input  logic       memread,
    output logic       lu
);

    // A load into x0 never produces a value, so it can never cause a hazard.
    assign lu = memread && (rd != REG_X0) &&
                ((rd == rs1) || (uses_rs2 && (rd == rs2)));

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - IF/ID and ID/EX sequencing: load-use stall, branch flush, mem-busy freeze
// Optional perf counters enabled by PIPE_HAZARD_CTRL_PERF_EN.
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int unsigned LU_STALL     = 1,
    parameter int unsigned FLUSH_CYCLES = 1,
    parameter int unsigned CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       if_id_rs1,
    input  logic [4:0]       if_id_rs2,
    input  logic             if_id_uses_rs2,
    input  logic [4:0]       id_ex_rd,
    input  logic             id_ex_memread,
    input  logic             branch_taken,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_bubble,
    output logic             ex_mem_hold,
    output logic [1:0]       ctrl_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] busy_cnt
);

    localparam int   LU_INIT_I = (LU_STALL > 1) ? int'(LU_STALL) - 2 : 0;
    localparam int   FL_INIT_I = (FLUSH_CYCLES > 1) ? int'(FLUSH_CYCLES) - 2 : 0;
    localparam cnt_t LU_INIT   = cnt_t'(LU_INIT_I);
    localparam cnt_t FL_INIT   = cnt_t'(FL_INIT_I);

    ctrl_state_t state, state_nxt;
    cnt_t        cnt, cnt_nxt;
    logic        lu;

    pipe_hazard_cmp u_cmp (
        .rs1      (if_id_rs1),
        .rs2      (if_id_rs2),
        .uses_rs2 (if_id_uses_rs2),
        .rd       (id_ex_rd),
        .memread  (id_ex_memread),
        .lu       (lu)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        if_id_flush  = 1'b0;
        id_ex_bubble = 1'b0;
        ex_mem_hold  = 1'b0;
        if (mem_busy) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            ex_mem_hold = 1'b1;
        end else if (branch_taken) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (FLUSH_CYCLES > 1) begin
                state_nxt = FLUSH;
                cnt_nxt   = FL_INIT;
            end else begin
                state_nxt = RUN;
            end
        end else if ((state == RUN && lu) || state == STALL) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            if (state == STALL) begin
                if (cnt == '0) state_nxt = RUN;
                else           cnt_nxt   = cnt - 4'd1;
            end else if (LU_STALL > 1) begin
                state_nxt = STALL;
                cnt_nxt   = LU_INIT;
            end
        end else if (state == FLUSH) begin
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            if (cnt == '0) state_nxt = RUN;
            else           cnt_nxt   = cnt - 4'd1;
        end else if (state != RUN) begin
            state_nxt = RUN;
        end
        // Reset overrides everything so IF/ID and ID/EX fill with NOPs.
        if (!reset) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            ex_mem_hold  = 1'b0;
        end
    end

    assign ctrl_state = state;

`ifdef PIPE_HAZARD_CTRL_PERF_EN
    logic             stall_evt, flush_evt, busy_evt;
    logic [CNT_W-1:0] stall_q, flush_q, busy_q;
    localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    // Each cycle class has a unique output signature; reset cycles match none.
    assign stall_evt = !pc_write && id_ex_bubble && !if_id_flush;
    assign flush_evt = pc_write && if_id_flush;
    assign busy_evt  = ex_mem_hold;

    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_q <= '0;
            flush_q <= '0;
            busy_q  <= '0;
        end else begin
            if (stall_evt && stall_q != '1) stall_q <= stall_q + ONE;
            if (flush_evt && flush_q != '1) flush_q <= flush_q + ONE;
            if (busy_evt  && busy_q  != '1) busy_q  <= busy_q + ONE;
        end
    end

    assign stall_cnt = stall_q;
    assign flush_cnt = flush_q;
    assign busy_cnt  = busy_q;
`else
    assign stall_cnt = '0;
    assign flush_cnt = '0;
    assign busy_cnt  = '0;
`endif

endmodule
